// File: rtl/encoder_8_to_3_seq_if.sv
// Handshake bundle for the sequential 8-to-3 encoder.
// The request side loads a vector and the code side drains it with valid/ready beats.
interface encoder_8_to_3_seq_if #(
    parameter int N_IN = 8
);
    localparam int W_OUT = $clog2(N_IN);

    logic             in_load;
    logic [N_IN-1:0]  in_a;
    logic             in_ready;
    logic             out_valid;
    logic [W_OUT-1:0] out_y;
    logic             out_last;
    logic             out_busy;
    logic [W_OUT:0]   out_count;
    logic             out_err;

    modport master (
        output in_load, in_a, in_ready,
        input  out_valid, out_y, out_last, out_busy, out_count, out_err
    );

    modport slave (
        input  in_load, in_a, in_ready,
        output out_valid, out_y, out_last, out_busy, out_count, out_err
    );
endinterface

// File: rtl/encoder_8_to_3_seq.sv
// Sequential 8-to-3 encoder: captures a multi-hot request vector and
// serialises the index of every set bit, one per accepted beat, in priority order.
module encoder_8_to_3_seq #(
    parameter int N_IN      = 8,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                 in_clk,
    input  logic                 in_rst_n,
    encoder_8_to_3_seq_if.slave  bus
);
    localparam int W_OUT = $clog2(N_IN);

    typedef enum logic {
        IDLE,
        DRAIN
    } state_t;

    state_t           state_q;
    logic [N_IN-1:0]  pending_q;
    logic [N_IN-1:0]  pending_d;
    logic             valid_q;
    logic             busy_q;
    logic             err_q;
    logic [W_OUT-1:0] selIdx;
    logic [W_OUT:0]   popCount;

    // Code, count and the post-acceptance vector depend on pending only, never on inputs.
    always_comb begin
        selIdx   = '0;
        popCount = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (MSB_FIRST) begin
                if (pending_q[i]) selIdx = W_OUT'(i);
            end else begin
                if (pending_q[N_IN-1-i]) selIdx = W_OUT'(N_IN-1-i);
            end
            popCount = popCount + (W_OUT+1)'(pending_q[i]);
        end
        pending_d = pending_q & ~(N_IN'(1) << selIdx);
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state_q   <= IDLE;
            pending_q <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.in_load) begin
                        if (bus.in_a != '0) begin
                            pending_q <= bus.in_a;
                            state_q   <= DRAIN;
                            valid_q   <= 1'b1;
                            busy_q    <= 1'b1;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    // Loads are ignored here, even on the cycle the last beat leaves.
                    if (bus.in_ready) begin
                        pending_q <= pending_d;
                        if (popCount == (W_OUT+1)'(1)) begin
                            state_q <= IDLE;
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    pending_q <= '0;
                    valid_q   <= 1'b0;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.out_busy  = busy_q;
    assign bus.out_err   = err_q;
    assign bus.out_y     = selIdx;
    assign bus.out_count = popCount;
    assign bus.out_last  = (popCount == (W_OUT+1)'(1));
endmodule
